// File: rtl/plca_pkg.sv
// Shared PLCA types and constants used by the transmit delay line and its storage.
package plca_pkg;

    localparam int PLCA_DL_DEPTH_MAX = 128;

    // One delay-line slot, bit-packed as {txer, txen, txd[3:0]}.
    typedef struct packed {
        logic       txer;
        logic       txen;
        logic [3:0] txd;
    } plca_dl_entry_t;

    localparam plca_dl_entry_t PLCA_DL_IDLE = '{txer: 1'b0, txen: 1'b0, txd: 4'h0};

endpackage

// File: rtl/plca_dl_ram.sv
// Single-write-port, asynchronous-read storage for the PLCA delay line.
import plca_pkg::*;

module plca_dl_ram #(
    parameter int DEPTH = PLCA_DL_DEPTH_MAX,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [5:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [5:0]    o_rdata
);

    // Contents are never reset so that a technology RAM can replace this array.
    logic [5:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/plca_tx_delay_line.sv
// PLCA transmit delay line: buffers the MAC nibble stream on each mcd strobe and
// returns it delayed by 'a' strobes, with fill level and sticky overrun status.
import plca_pkg::*;

module plca_tx_delay_line #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic       tx_clk,
    input  logic       plca_reset_n,
    input  logic       plca_reset,
    input  logic       mcd,
    input  logic [3:0] plca_txd,
    input  logic       plca_txen,
    input  logic       plca_txer,
    input  logic [6:0] a,
    input  logic [7:0] delay_line_length,
    output logic [3:0] plca_txdn_a,
    output logic       plca_txenn_a,
    output logic       plca_txern_a,
    output logic [7:0] fill,
    output logic       dl_overrun
);

    localparam logic [7:0] FILL_MAX = 8'(DEPTH - 1);

    logic [AW-1:0]  r_wrPtr;
    logic [7:0]     r_fill;
    logic           r_overrun;

    logic           w_we;
    logic           w_overrunHit;
    logic [AW-1:0]  w_rdAddr;
    logic [5:0]     w_rdRaw;
    plca_dl_entry_t w_inEntry;
    plca_dl_entry_t w_rdEntry;
    plca_dl_entry_t w_outEntry;

    // A synchronous PLCA reset on the same edge as mcd discards that write.
    assign w_we         = mcd && !plca_reset;
    assign w_inEntry    = '{txer: plca_txer, txen: plca_txen, txd: plca_txd};
    assign w_rdAddr     = r_wrPtr - AW'(a);
    assign w_rdEntry    = plca_dl_entry_t'(w_rdRaw);
    assign w_overrunHit = (8'(a) > delay_line_length) || (int'(a) > DEPTH - 1);

    plca_dl_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (tx_clk),
        .i_we    (w_we),
        .i_waddr (r_wrPtr),
        .i_wdata (w_inEntry),
        .i_raddr (w_rdAddr),
        .o_rdata (w_rdRaw)
    );

    always_ff @(posedge tx_clk or negedge plca_reset_n) begin
        if (!plca_reset_n) begin
            r_wrPtr   <= '0;
            r_fill    <= '0;
            r_overrun <= 1'b0;
        end else if (plca_reset) begin
            r_wrPtr   <= '0;
            r_fill    <= '0;
            r_overrun <= 1'b0;
        end else if (mcd) begin
            r_wrPtr <= r_wrPtr + 1'b1;
            if (r_fill < FILL_MAX) begin
                r_fill <= r_fill + 8'd1;
            end
            if (w_overrunHit) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Delays beyond what has been written since reset read as IDLE rather than stale data.
    always_comb begin
        w_outEntry = PLCA_DL_IDLE;
        if (a == 7'd0) begin
            w_outEntry = w_inEntry;
        end else if (8'(a) <= r_fill) begin
            w_outEntry = w_rdEntry;
        end
    end

    assign plca_txdn_a  = w_outEntry.txd;
    assign plca_txenn_a = w_outEntry.txen;
    assign plca_txern_a = w_outEntry.txer;
    assign fill         = r_fill;
    assign dl_overrun   = r_overrun;

endmodule

// File: tb/tb_plca_tx_delay_line.sv
// Scoreboard testbench for plca_tx_delay_line: directed stimulus pushes expected
// outputs into a queue, and a monitor pops and compares them on the falling edge.
module tb_plca_tx_delay_line;

    logic       tx_clk;
    logic       plca_reset_n;
    logic       plca_reset;
    logic       mcd;
    logic [3:0] plca_txd;
    logic       plca_txen;
    logic       plca_txer;
    logic [6:0] a;
    logic [7:0] delay_line_length;
    logic [3:0] plca_txdn_a;
    logic       plca_txenn_a;
    logic       plca_txern_a;
    logic [7:0] fill;
    logic       dl_overrun;

    typedef struct {
        string      name;
        logic [3:0] txd;
        logic       txen;
        logic       txer;
        logic [7:0] fill;
        logic       ovr;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    plca_tx_delay_line dut (
        .tx_clk            (tx_clk),
        .plca_reset_n      (plca_reset_n),
        .plca_reset        (plca_reset),
        .mcd               (mcd),
        .plca_txd          (plca_txd),
        .plca_txen         (plca_txen),
        .plca_txer         (plca_txer),
        .a                 (a),
        .delay_line_length (delay_line_length),
        .plca_txdn_a       (plca_txdn_a),
        .plca_txenn_a      (plca_txenn_a),
        .plca_txern_a      (plca_txern_a),
        .fill              (fill),
        .dl_overrun        (dl_overrun)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    // Monitor: every expectation queued before a falling edge is compared at that edge.
    always @(negedge tx_clk) begin
        while (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checks += 5;
            if (plca_txdn_a !== e.txd) begin
                errors++;
                $display("[TB] FAIL %s.txd got %h expected %h", e.name, plca_txdn_a, e.txd);
            end
            if (plca_txenn_a !== e.txen) begin
                errors++;
                $display("[TB] FAIL %s.txen got %b expected %b", e.name, plca_txenn_a, e.txen);
            end
            if (plca_txern_a !== e.txer) begin
                errors++;
                $display("[TB] FAIL %s.txer got %b expected %b", e.name, plca_txern_a, e.txer);
            end
            if (fill !== e.fill) begin
                errors++;
                $display("[TB] FAIL %s.fill got %0d expected %0d", e.name, fill, e.fill);
            end
            if (dl_overrun !== e.ovr) begin
                errors++;
                $display("[TB] FAIL %s.overrun got %b expected %b", e.name, dl_overrun, e.ovr);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // One mcd strobe carrying the given nibble, followed by an idle cycle.
    task automatic applyStimulus(input logic [3:0] txd, input logic txen, input logic txer);
        @(posedge tx_clk);
        #1;
        plca_txd  = txd;
        plca_txen = txen;
        plca_txer = txer;
        mcd       = 1'b1;
        @(posedge tx_clk);
        #1;
        mcd = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] txd, input logic txen,
                               input logic txer, input logic [7:0] expFill, input logic ovr);
        exp_t e;
        e.name = name;
        e.txd  = txd;
        e.txen = txen;
        e.txer = txer;
        e.fill = expFill;
        e.ovr  = ovr;
        expQ.push_back(e);
        @(negedge tx_clk);
        #1;
    endtask

    task automatic asyncReset();
        @(posedge tx_clk);
        #1 plca_reset_n = 1'b0;
        #2 plca_reset_n = 1'b1;
    endtask

    initial begin
        plca_reset_n      = 1'b0;
        plca_reset        = 1'b0;
        mcd               = 1'b0;
        plca_txd          = 4'h0;
        plca_txen         = 1'b0;
        plca_txer         = 1'b0;
        a                 = 7'd0;
        delay_line_length = 8'd127;
        repeat (3) @(posedge tx_clk);
        #1 plca_reset_n = 1'b1;

        $display("[TB] reset and pass-through");
        plca_txd = 4'h5;
        a = 7'd0;
        checkOutput("passthru", 4'h5, 1'b0, 1'b0, 8'd0, 1'b0);
        a = 7'd1;
        checkOutput("resetIdle", 4'h0, 1'b0, 1'b0, 8'd0, 1'b0);

        $display("[TB] fixed delay");
        a = 7'd0;
        for (int i = 1; i <= 10; i++) applyStimulus(4'(i), 1'b1, 1'b0);
        a = 7'd3;
        checkOutput("delay3", 4'h8, 1'b1, 1'b0, 8'd10, 1'b0);
        a = 7'd1;
        checkOutput("delay1", 4'hA, 1'b1, 1'b0, 8'd10, 1'b0);
        a = 7'd10;
        checkOutput("delayFill", 4'h1, 1'b1, 1'b0, 8'd10, 1'b0);
        a = 7'd11;
        checkOutput("delayOverFill", 4'h0, 1'b0, 1'b0, 8'd10, 1'b0);

        $display("[TB] underfill after synchronous reset");
        a = 7'd0;
        @(posedge tx_clk);
        #1 plca_reset = 1'b1;
        @(posedge tx_clk);
        #1 plca_reset = 1'b0;
        applyStimulus(4'hA, 1'b1, 1'b0);
        applyStimulus(4'hB, 1'b1, 1'b0);
        a = 7'd5;
        checkOutput("underfill", 4'h0, 1'b0, 1'b0, 8'd2, 1'b0);
        a = 7'd0;
        applyStimulus(4'hC, 1'b1, 1'b0);
        applyStimulus(4'hD, 1'b1, 1'b0);
        applyStimulus(4'hE, 1'b1, 1'b0);
        a = 7'd5;
        checkOutput("underfillDone", 4'hA, 1'b1, 1'b0, 8'd5, 1'b0);

        $display("[TB] wrap-around");
        a = 7'd0;
        asyncReset();
        for (int i = 0; i < 128; i++) applyStimulus(4'(i % 16), 1'b1, 1'(i % 2));
        a = 7'd1;
        checkOutput("wrapPtrZero", 4'hF, 1'b1, 1'b1, 8'd127, 1'b0);
        a = 7'd0;
        for (int i = 128; i < 200; i++) applyStimulus(4'(i % 16), 1'b1, 1'(i % 2));
        a = 7'd127;
        checkOutput("wrap127", 4'h9, 1'b1, 1'b1, 8'd127, 1'b0);
        a = 7'd64;
        checkOutput("wrap64", 4'h8, 1'b1, 1'b0, 8'd127, 1'b0);

        $display("[TB] overrun");
        delay_line_length = 8'd20;
        a = 7'd20;
        applyStimulus(4'h3, 1'b1, 1'b0);
        checkOutput("atLimit", 4'h5, 1'b1, 1'b1, 8'd127, 1'b0);
        a = 7'd21;
        applyStimulus(4'h8, 1'b1, 1'b0);
        checkOutput("overrunSet", 4'h5, 1'b1, 1'b1, 8'd127, 1'b1);
        a = 7'd0;
        checkOutput("overrunSticky", 4'h8, 1'b1, 1'b0, 8'd127, 1'b1);
        applyStimulus(4'h2, 1'b0, 1'b0);
        checkOutput("overrunHold", 4'h2, 1'b0, 1'b0, 8'd127, 1'b1);
        asyncReset();
        a = 7'd1;
        checkOutput("overrunClear", 4'h0, 1'b0, 1'b0, 8'd0, 1'b0);

        $display("[TB] simultaneous mcd and reset");
        delay_line_length = 8'd127;
        a = 7'd0;
        applyStimulus(4'h6, 1'b1, 1'b0);
        @(posedge tx_clk);
        #1;
        plca_txd   = 4'h9;
        plca_txen  = 1'b1;
        plca_reset = 1'b1;
        mcd        = 1'b1;
        @(posedge tx_clk);
        #1;
        plca_reset = 1'b0;
        mcd        = 1'b0;
        a = 7'd1;
        checkOutput("simulReset", 4'h0, 1'b0, 1'b0, 8'd0, 1'b0);
        a = 7'd0;
        applyStimulus(4'h4, 1'b1, 1'b1);
        a = 7'd1;
        checkOutput("afterSimul", 4'h4, 1'b1, 1'b1, 8'd1, 1'b0);

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(posedge tx_clk);
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain got %0d pending expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
